// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM state codes,
// per-stage stall encodings and the stall priority helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Bit order: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam int STAT_W = 32;

  // An execute-stage hold already freezes everything decode would freeze.
  function automatic logic [5:0] stall_vec(input logic ex_req, input logic id_req);
    if (ex_req)      return STALL_EX;
    else if (id_req) return STALL_ID;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl.
// stall_cycles exists only when PIPE_CTRL_STATS_EN is defined.
interface pipe_ctrl_if #(parameter int CNT_W = 6);

  logic             stallreq_id;
  logic             ex_mc_start;
  logic [CNT_W-1:0] ex_mc_len;
  logic             flush;
  logic [5:0]       stall;
  logic             mc_busy;
  logic             mc_done;
`ifdef PIPE_CTRL_STATS_EN
  logic [31:0]      stall_cycles;
`endif

  modport master (
    output stallreq_id, ex_mc_start, ex_mc_len, flush,
    input  stall, mc_busy, mc_done
`ifdef PIPE_CTRL_STATS_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  stallreq_id, ex_mc_start, ex_mc_len, flush,
    output stall, mc_busy, mc_done
`ifdef PIPE_CTRL_STATS_EN
    , output stall_cycles
`endif
  );

endinterface

// File: rtl/pipe_stat_cnt.sv
// Saturating count of cycles in which the PC is held; synchronous clear.
// Instantiated by pipe_ctrl only when PIPE_CTRL_STATS_EN is defined.
module pipe_stat_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  logic [STAT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (inc && (cnt_q != '1))
      cnt_q <= cnt_q + STAT_W'(1);
  end

  // The register only clears at the edge, so mask it while reset is held.
  assign count = rst ? '0 : cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: multi-cycle execute FSM plus stall priority.
// Define PIPE_CTRL_STATS_EN to add the stall_cycles statistics counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.slave    bus
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             ex_req;
  logic [5:0]       stall_int;

  // NOTE: state is updated with non-blocking assignments so every reader
  // sees the pre-edge value, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.ex_mc_start) begin
            if (bus.ex_mc_len != '0) begin
              state <= ST_BUSY;
              cnt   <= bus.ex_mc_len - CNT_W'(1);
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A flush cancels the hold in the same cycle it arrives.
  assign ex_req = !bus.flush &&
                  (((state == ST_IDLE) && bus.ex_mc_start) || (state == ST_BUSY));

  assign stall_int   = rst ? STALL_NONE : stall_vec(ex_req, bus.stallreq_id);
  assign bus.stall   = stall_int;
  assign bus.mc_busy = !rst && (state == ST_BUSY);
  assign bus.mc_done = !rst && !bus.flush && (state == ST_DONE);

`ifdef PIPE_CTRL_STATS_EN
  pipe_stat_cnt u_stat (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_int[0]),
    .count (bus.stall_cycles)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; stall_cycles checks are
// compiled in only when PIPE_CTRL_STATS_EN is defined.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 6;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: apply inputs after the falling edge, let them settle.
  task automatic drv(input logic r, input logic id, input logic st,
                     input logic [CNT_W-1:0] len, input logic fl);
    @(negedge clk);
    rst             = r;
    bus.stallreq_id = id;
    bus.ex_mc_start = st;
    bus.ex_mc_len   = len;
    bus.flush       = fl;
    #1;
  endtask

  task automatic outs(input string tag, input logic [5:0] st, input logic busy, input logic done);
    check({tag, ".stall"}, 32'(bus.stall), 32'(st));
    check({tag, ".busy"},  32'(bus.mc_busy), 32'(busy));
    check({tag, ".done"},  32'(bus.mc_done), 32'(done));
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.stallreq_id = 1'b0;
    bus.ex_mc_start = 1'b0;
    bus.ex_mc_len   = '0;
    bus.flush       = 1'b0;

    // Reset held with every request active: outputs forced low.
    drv(1, 1, 1, 6'd3, 0); outs("rst0", STALL_NONE, 0, 0);
    drv(1, 1, 1, 6'd3, 1); outs("rst1", STALL_NONE, 0, 0);
`ifdef PIPE_CTRL_STATS_EN
    check("rst.stats", bus.stall_cycles, 32'd0);
`endif

    // Test 1: decode stall alone.
    drv(0, 1, 0, 6'd0, 0); outs("t1", STALL_ID, 0, 0);
    // Execute request wins over decode; len 0 goes straight to DONE.
    drv(0, 1, 1, 6'd0, 0); outs("prio.start", STALL_EX, 0, 0);
    drv(0, 1, 0, 6'd0, 0); outs("prio.done", STALL_ID, 0, 1);
    drv(0, 0, 0, 6'd0, 0); outs("prio.idle", STALL_NONE, 0, 0);

    // Test 2: len 4 -> 5 EX cycles, DONE, IDLE; start held high is ignored.
    drv(0, 0, 1, 6'd4, 0); outs("t2.start", STALL_EX, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drv(0, 0, 1, 6'd7, 0); outs($sformatf("t2.busy%0d", i), STALL_EX, 1, 0);
    end
    drv(0, 0, 1, 6'd7, 0); outs("t2.done", STALL_NONE, 0, 1);
    drv(0, 0, 0, 6'd0, 0); outs("t2.idle", STALL_NONE, 0, 0);

    // Test 3: len 0.
    drv(0, 0, 1, 6'd0, 0); outs("t3.start", STALL_EX, 0, 0);
    drv(0, 0, 0, 6'd0, 0); outs("t3.done", STALL_NONE, 0, 1);
    drv(0, 0, 0, 6'd0, 0); outs("t3.idle", STALL_NONE, 0, 0);

    // Test 4: len 8, flush on the 3rd BUSY cycle.
    drv(0, 0, 1, 6'd8, 0); outs("t4.start", STALL_EX, 0, 0);
    drv(0, 0, 0, 6'd0, 0); outs("t4.busy1", STALL_EX, 1, 0);
    drv(0, 0, 0, 6'd0, 0); outs("t4.busy2", STALL_EX, 1, 0);
    drv(0, 0, 0, 6'd0, 1); outs("t4.flush", STALL_NONE, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drv(0, 0, 0, 6'd0, 0); outs($sformatf("t4.after%0d", i), STALL_NONE, 0, 0);
    end

    // Flush coinciding with a start: request is dropped.
    drv(0, 0, 1, 6'd3, 1); outs("fl.start", STALL_NONE, 0, 0);
    drv(0, 0, 0, 6'd0, 0); outs("fl.idle", STALL_NONE, 0, 0);

    // Test 5: reset mid-BUSY with len 10.
    drv(0, 0, 1, 6'd10, 0); outs("t5.start", STALL_EX, 0, 0);
    drv(0, 0, 0, 6'd0, 0);  outs("t5.busy1", STALL_EX, 1, 0);
    drv(0, 0, 0, 6'd0, 0);  outs("t5.busy2", STALL_EX, 1, 0);
    drv(1, 1, 1, 6'd5, 0);  outs("t5.rst", STALL_NONE, 0, 0);
`ifdef PIPE_CTRL_STATS_EN
    check("t5.rst.stats", bus.stall_cycles, 32'd0);
`endif
    drv(0, 0, 0, 6'd0, 0);  outs("t5.idle", STALL_NONE, 0, 0);
`ifdef PIPE_CTRL_STATS_EN
    check("t5.idle.stats", bus.stall_cycles, 32'd0);
`endif
    drv(0, 0, 1, 6'd4, 0);  outs("t5r.start", STALL_EX, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drv(0, 0, 0, 6'd0, 0); outs($sformatf("t5r.busy%0d", i), STALL_EX, 1, 0);
    end
    drv(0, 0, 0, 6'd0, 0);  outs("t5r.done", STALL_NONE, 0, 1);

    // Three decode stalls, then the statistics total.
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, 6'd0, 0); outs($sformatf("t6.id%0d", i), STALL_ID, 0, 0);
    end
    drv(0, 0, 0, 6'd0, 0);  outs("t6.idle", STALL_NONE, 0, 0);
`ifdef PIPE_CTRL_STATS_EN
    check("t6.total", bus.stall_cycles, 32'd8);

    // Saturation: preload one below the ceiling, then keep stalling.
    @(negedge clk);
    force dut.u_stat.cnt_q = 32'hFFFF_FFFE;
    bus.stallreq_id = 1'b1;
    #1;
    release dut.u_stat.cnt_q;
    check("t6.preload", bus.stall_cycles, 32'hFFFF_FFFE);
    drv(0, 1, 0, 6'd0, 0); check("t6.sat0", bus.stall_cycles, 32'hFFFF_FFFF);
    drv(0, 1, 0, 6'd0, 0); check("t6.sat1", bus.stall_cycles, 32'hFFFF_FFFF);
    drv(0, 1, 0, 6'd0, 0); check("t6.sat2", bus.stall_cycles, 32'hFFFF_FFFF);
`endif

    drv(0, 0, 0, 6'd0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: CNT_W, default 6, width of the multi-cycle length field and the internal down-counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 stallreq_id  input  1  decode-stage hazard stall request, level, combinational from decode.
REQ-005 ex_mc_start  input  1  execute stage requests a multi-cycle operation this cycle.
REQ-006 ex_mc_len  input  CNT_W  number of busy cycles for the requested operation, unsigned.
REQ-007 flush  input  1  cancel any in-flight multi-cycle operation (branch/exception).
REQ-008 stall  output  6  per-stage hold vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-009 mc_busy  output  1  high while the FSM is in BUSY.
REQ-010 mc_done  output  1  one-cycle pulse telling execute to latch its multi-cycle result.
REQ-011 stall_cycles  output  32  stall statistics (present only under PIPE_CTRL_STATS_EN).

Function
REQ-012 FSM states SHALL be IDLE, BUSY and DONE, held in a registered state with a registered down-counter cnt of CNT_W bits.
REQ-013 IDLE with ex_mc_start=1 and flush=0: next state BUSY with cnt <= ex_mc_len-1 if ex_mc_len!=0; next state DONE directly if ex_mc_len==0.
REQ-014 BUSY: cnt decrements each cycle; when cnt==0 the next state is DONE.
REQ-015 DONE: mc_done=1 for exactly this cycle; next state IDLE unconditionally.
REQ-016 ex_mc_start SHALL be ignored in BUSY and DONE.
REQ-017 The ex stall request is combinational: ex_req = (state==IDLE && ex_mc_start && !flush) || state==BUSY.
REQ-018 stall SHALL be 6'b001111 when ex_req=1, else 6'b000111 when stallreq_id=1, else 6'b000000; ex has priority over id.
REQ-019 For length L>=1, stall is 001111 for L+1 consecutive cycles (start cycle plus L BUSY cycles), then 000000 in DONE (unless stallreq_id).
REQ-020 For L=0, stall is 001111 only in the start cycle, followed by one DONE cycle.
REQ-021 flush=1 in any state: next state IDLE, cnt <= 0, no mc_done pulse generated; in that cycle ex_req=0 and mc_done=0.
REQ-022 mc_busy = (state==BUSY), combinational from the state register.

Reset
REQ-023 rst=1 at a clock edge SHALL force state IDLE and cnt 0, overriding start and flush, including mid-BUSY.
REQ-024 While rst=1, stall=6'b000000, mc_busy=0, mc_done=0 and stall_cycles=0, regardless of the other inputs.

Configuration
REQ-025 Macro PIPE_CTRL_STATS_EN defined: stall_cycles is a 32-bit register that increments on every cycle with stall[0]=1, saturates at 32'hFFFFFFFF, and is cleared by rst.
REQ-026 Macro PIPE_CTRL_STATS_EN undefined: the stall_cycles port and its counter SHALL NOT exist; all other behaviour is identical.

Structure
REQ-027 Stall vector encodings (STALL_NONE 000000, STALL_ID 000111, STALL_EX 001111) and the FSM state codes SHALL live in the shared defines.v.
REQ-028 The statistics counter SHALL be the sub-module pipe_stat_cnt, instantiated only under PIPE_CTRL_STATS_EN; the FSM stays in pipe_ctrl.

Verification
REQ-029 Test 1: stallreq_id=1 alone, IDLE -> stall=000111 in the same cycle; mc_busy=0.
REQ-030 Test 2: ex_mc_start=1 with len=4 in one cycle -> stall=001111 for 5 cycles; mc_done=1 and stall=000000 in the 6th cycle; IDLE in the 7th.
REQ-031 Test 3: len=0 -> stall=001111 for 1 cycle; mc_done in the next cycle; IDLE after that.
REQ-032 Test 4: len=8 with flush at the 3rd BUSY cycle -> stall=000000 and mc_done=0 in the flush cycle; IDLE next; no mc_done afterwards.
REQ-033 Test 5: rst asserted mid-BUSY (len=10) -> next cycle IDLE, all outputs 0; a new start after reset release behaves as in Test 2.
REQ-034 Test 6 (PIPE_CTRL_STATS_EN): Test 2 followed by 3 cycles of stallreq_id -> stall_cycles=8; a preloaded FFFFFFFF value holds under further stalls.
